sad_job_dispatcher: RTL and testbench
=====================================

SAD_JOB_DISPATCHER -- requirements
Module: sad_job_dispatcher

Interface
REQ-001 Parameter NUM_LANES, default 8, number of SAD worker lanes.
REQ-002 Parameter COORD_W, default 8, width of row/column window coordinates.
REQ-003 Parameter SAD_W, default 32, width of one SAD value.
REQ-004 Clk  input  1  single clock; all state on rising edge.
REQ-005 Rst  input  1  reset, asynchronous, active-high.
REQ-006 Start  input  1  begin a search; sampled only in IDLE or DONE.
REQ-007 MaxRow  input  COORD_W  last window row index; latched on accepted Start.
REQ-008 MaxCol  input  COORD_W  last window column index; latched on accepted Start.
REQ-009 JobValid  output  NUM_LANES  one-hot job offer to a lane.
REQ-010 JobReady  input  NUM_LANES  lane i can accept a job.
REQ-011 JobRow  output  COORD_W  row of offered window (shared bus).
REQ-012 JobCol  output  COORD_W  column of offered window (shared bus).
REQ-013 ResValid  input  NUM_LANES  lane i presents a result this cycle.
REQ-014 ResSAD  input  NUM_LANES*SAD_W  per-lane SAD, lane i at bits [i*SAD_W +: SAD_W].
REQ-015 ResRow, ResCol  input  NUM_LANES*COORD_W each  per-lane window coordinates of result.
REQ-016 MinSAD  output  SAD_W  running minimum SAD.
REQ-017 MinRow, MinCol  output  COORD_W each  coordinates of MinSAD.
REQ-018 Busy  output  1  high in ISSUE or DRAIN.
REQ-019 Done  output  1  high in DONE.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, DRAIN, DONE.
REQ-021 IDLE/DONE + Start: latch MaxRow/MaxCol, row=col=0, MinSAD=all ones, MinRow=MinCol=0, clear all Pending bits, go ISSUE.
REQ-022 Per-lane Pending bit SHALL be set on job handshake, cleared on ResValid for that lane.
REQ-023 In ISSUE, JobValid SHALL be one-hot on the lowest-index lane with JobReady=1 and Pending=0, else all zero; combinational from JobReady/Pending/state.
REQ-024 JobValid SHALL be zero outside ISSUE; JobRow/JobCol SHALL equal the current row/col counters at all times.
REQ-025 Handshake = JobValid[i]&JobReady[i]; at most one job issued per cycle.
REQ-026 On handshake: col==MaxCol -> col=0, row+1; else col+1; issue of (MaxRow,MaxCol) -> DRAIN instead of advancing.
REQ-027 Job order SHALL be raster: column fastest; total jobs (MaxRow+1)*(MaxCol+1); MaxRow=MaxCol=0 issues exactly one job.
REQ-028 DRAIN: all Pending clear -> DONE on next edge; Start ignored in ISSUE and DRAIN.
REQ-029 ResValid[i] with Pending[i]=0 SHALL be ignored (no compare, no state change).
REQ-030 Results are never back-pressured; any number of lanes may return in one cycle.
REQ-031 Minimum update: among valid results this cycle plus stored min, select strictly smallest SAD; tie -> stored min kept, else lowest lane index wins.
REQ-032 MinSAD/MinRow/MinCol SHALL update on the edge ending the ResValid cycle (latency 1).
REQ-033 Result accepted in the same cycle as a handshake on another lane SHALL be processed normally; lane freed by a result is eligible from next cycle.
REQ-034 DONE SHALL hold Min* and Done stable until next Start.

Reset
REQ-035 Rst high SHALL force IDLE, Pending=0, row=col=0, MinSAD=all ones, MinRow=MinCol=0, JobValid=0, Busy=0, Done=0, immediately without waiting for Clk.
REQ-036 Rst mid-search SHALL abandon outstanding jobs; later ResValid ignored as in REQ-029.

Verification
REQ-037 MaxRow=1, MaxCol=2, all JobReady=1 -> jobs (0,0)..(1,2) raster to lanes 0..5 on consecutive cycles, then DRAIN.
REQ-038 JobReady=8'b0000_0100 only -> every job goes to lane 2, next one only after lane 2 result clears Pending.
REQ-039 Lanes 3 and 5 return SAD 40 and 40 same cycle, stored min 100 -> MinSAD=40 with lane 3 coordinates, next edge.
REQ-040 Stored min 40, new result 40 -> Min* unchanged; result 39 -> MinSAD=39.
REQ-041 ResValid on a lane with Pending=0, SAD=0 -> MinSAD unchanged, no Done change.
REQ-042 Rst asserted in DRAIN between edges -> outputs at reset values immediately; Start afterwards runs a clean search to Done=1.

Source files
------------

// File: rtl/sad_job_dispatcher.sv
// Purpose : hands raster-ordered SAD search windows to worker lanes and keeps the running minimum SAD.
// Latency : job offer is combinational on readiness; minimum updates on the edge ending the result cycle.
// Backpr. : jobs wait for a free, ready lane; results are never back-pressured.
//
// Ports:
//   i_clk, i_rst             clock, asynchronous active-high reset
//   i_start                  begin a search (accepted only when idle or done)
//   i_max_row, i_max_col     last window row/column, latched on accepted start
//   o_job_valid/i_job_ready  one-hot job offer / per-lane ready
//   o_job_row, o_job_col     shared coordinate bus of the offered window
//   i_res_valid/_sad/_row/_col  per-lane results, lane i at slice i
//   o_min_sad/_row/_col      running minimum and its coordinates
//   o_busy, o_done           search in progress / search finished
module sad_job_dispatcher #(
    parameter int NUM_LANES = 8,
    parameter int COORD_W   = 8,
    parameter int SAD_W     = 32
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic [COORD_W-1:0]             i_max_row,
    input  logic [COORD_W-1:0]             i_max_col,
    output logic [NUM_LANES-1:0]           o_job_valid,
    input  logic [NUM_LANES-1:0]           i_job_ready,
    output logic [COORD_W-1:0]             o_job_row,
    output logic [COORD_W-1:0]             o_job_col,
    input  logic [NUM_LANES-1:0]           i_res_valid,
    input  logic [NUM_LANES*SAD_W-1:0]     i_res_sad,
    input  logic [NUM_LANES*COORD_W-1:0]   i_res_row,
    input  logic [NUM_LANES*COORD_W-1:0]   i_res_col,
    output logic [SAD_W-1:0]               o_min_sad,
    output logic [COORD_W-1:0]             o_min_row,
    output logic [COORD_W-1:0]             o_min_col,
    output logic                           o_busy,
    output logic                           o_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [COORD_W-1:0]     r_row;
    logic [COORD_W-1:0]     r_col;
    logic [COORD_W-1:0]     r_max_row;
    logic [COORD_W-1:0]     r_max_col;
    logic [NUM_LANES-1:0]   r_pend;
    logic [SAD_W-1:0]       r_min_sad;
    logic [COORD_W-1:0]     r_min_row;
    logic [COORD_W-1:0]     r_min_col;
    logic                   r_busy;
    logic                   r_done;

    logic [NUM_LANES-1:0]   w_elig;
    logic [NUM_LANES-1:0]   w_grant;
    logic [NUM_LANES-1:0]   w_acc;
    logic                   w_hs;
    logic                   w_last;
    logic [SAD_W-1:0]       w_best_sad;
    logic [COORD_W-1:0]     w_best_row;
    logic [COORD_W-1:0]     w_best_col;

    // Lowest set bit of the eligible mask: x & (-x).
    assign w_elig      = i_job_ready & ~r_pend;
    assign w_grant     = w_elig & (~w_elig + {{(NUM_LANES-1){1'b0}}, 1'b1});
    assign o_job_valid = (r_state == S_ISSUE) ? w_grant : '0;
    // Any offered bit is already qualified by its ready, so offer == handshake.
    assign w_hs        = |o_job_valid;
    assign w_last      = (r_row == r_max_row) && (r_col == r_max_col);
    // Results from lanes without an outstanding job are dropped here.
    assign w_acc       = i_res_valid & r_pend;

    assign o_job_row = r_row;
    assign o_job_col = r_col;
    assign o_min_sad = r_min_sad;
    assign o_min_row = r_min_row;
    assign o_min_col = r_min_col;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

    // Ascending scan with strict less-than: the stored minimum survives ties,
    // and among equal new results the lowest lane wins.
    always_comb begin
        w_best_sad = r_min_sad;
        w_best_row = r_min_row;
        w_best_col = r_min_col;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_acc[i] && (i_res_sad[i*SAD_W +: SAD_W] < w_best_sad)) begin
                w_best_sad = i_res_sad[i*SAD_W +: SAD_W];
                w_best_row = i_res_row[i*COORD_W +: COORD_W];
                w_best_col = i_res_col[i*COORD_W +: COORD_W];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_row     <= '0;
            r_col     <= '0;
            r_max_row <= '0;
            r_max_col <= '0;
            r_pend    <= '0;
            r_min_sad <= '1;
            r_min_row <= '0;
            r_min_col <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_pend    <= (r_pend & ~w_acc) | o_job_valid;
            r_min_sad <= w_best_sad;
            r_min_row <= w_best_row;
            r_min_col <= w_best_col;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state   <= S_ISSUE;
                        r_max_row <= i_max_row;
                        r_max_col <= i_max_col;
                        r_row     <= '0;
                        r_col     <= '0;
                        r_pend    <= '0;
                        r_min_sad <= '1;
                        r_min_row <= '0;
                        r_min_col <= '0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (w_hs) begin
                        // Counters stay parked on the final window once it is issued.
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end else if (r_col == r_max_col) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_pend == '0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sad_job_dispatcher.sv
// Purpose : self-checking bench for sad_job_dispatcher against a count-based reference model.
// Latency : inputs change 1 time unit after the rising edge, outputs are compared 1 unit later.
// Backpr. : bench lanes hold results for a random number of cycles; readiness is fixed or random.
module tb_sad_job_dispatcher;

    localparam int NL = 8;
    localparam int CW = 8;
    localparam int SW = 32;

    logic              clk;
    logic              rst;
    logic              start;
    logic [CW-1:0]     max_row, max_col;
    logic [NL-1:0]     job_valid, job_ready;
    logic [CW-1:0]     job_row, job_col;
    logic [NL-1:0]     res_valid;
    logic [NL*SW-1:0]  res_sad;
    logic [NL*CW-1:0]  res_row, res_col;
    logic [SW-1:0]     min_sad;
    logic [CW-1:0]     min_row, min_col;
    logic              busy, done;

    sad_job_dispatcher #(.NUM_LANES(NL), .COORD_W(CW), .SAD_W(SW)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_max_row(max_row), .i_max_col(max_col),
        .o_job_valid(job_valid), .i_job_ready(job_ready),
        .o_job_row(job_row), .o_job_col(job_col),
        .i_res_valid(res_valid), .i_res_sad(res_sad),
        .i_res_row(res_row), .i_res_col(res_col),
        .o_min_sad(min_sad), .o_min_row(min_row), .o_min_col(min_col),
        .o_busy(busy), .o_done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Stimulus drive values for the next cycle.
    logic [NL-1:0] drv_ready, drv_res_v;
    logic          drv_start;
    logic [SW-1:0] drv_sad [NL];
    int            drv_mr, drv_mc;
    int            lat_lo, lat_hi;

    // Reference model: a search is "jobs issued so far out of total", a set of
    // lanes holding jobs, and the best (sad, arrival order) result seen.
    logic          m_busy, m_done;
    int            m_maxr, m_maxc, m_total, m_issued;
    logic [NL-1:0] m_out;
    logic [SW-1:0] m_min_sad;
    int            m_min_row, m_min_col;
    int            lane_row [NL];
    int            lane_col [NL];
    int            lane_t   [NL];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_row();
        if (m_issued >= m_total) return m_maxr;
        return m_issued / (m_maxc + 1);
    endfunction

    function automatic int exp_col();
        if (m_issued >= m_total) return m_maxc;
        return m_issued % (m_maxc + 1);
    endfunction

    task automatic m_reset();
        m_busy = 0; m_done = 0;
        m_maxr = 0; m_maxc = 0; m_total = 0; m_issued = 0;
        m_out = '0;
        m_min_sad = '1; m_min_row = 0; m_min_col = 0;
    endtask

    // One clock cycle: drive, compare, advance the model, cross the edge.
    task automatic tick();
        logic [NL-1:0] exp_jv;
        logic [NL-1:0] out0;
        int g;
        int iss0;
        job_ready = drv_ready;
        res_valid = drv_res_v;
        start     = drv_start;
        max_row   = CW'(drv_mr);
        max_col   = CW'(drv_mc);
        for (int i = 0; i < NL; i++) begin
            res_sad[i*SW +: SW] = drv_sad[i];
            res_row[i*CW +: CW] = CW'(lane_row[i]);
            res_col[i*CW +: CW] = CW'(lane_col[i]);
        end
        #1;
        exp_jv = '0;
        g = -1;
        if (m_busy && m_issued < m_total)
            for (int i = 0; i < NL; i++)
                if (g < 0 && drv_ready[i] && !m_out[i]) g = i;
        if (g >= 0) exp_jv[g] = 1'b1;
        chk("job_valid", 32'(job_valid), 32'(exp_jv));
        chk("job_row", 32'(job_row), exp_row());
        chk("job_col", 32'(job_col), exp_col());
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("min_sad", min_sad, m_min_sad);
        chk("min_row", 32'(min_row), m_min_row);
        chk("min_col", 32'(min_col), m_min_col);

        out0 = m_out;
        iss0 = m_issued;
        if (!m_busy && drv_start) begin
            m_busy = 1; m_done = 0;
            m_maxr = drv_mr; m_maxc = drv_mc;
            m_total = (drv_mr + 1) * (drv_mc + 1);
            m_issued = 0;
            m_out = '0;
            m_min_sad = '1; m_min_row = 0; m_min_col = 0;
        end else begin
            for (int i = 0; i < NL; i++)
                if (drv_res_v[i] && out0[i] && drv_sad[i] < m_min_sad) begin
                    m_min_sad = drv_sad[i];
                    m_min_row = lane_row[i];
                    m_min_col = lane_col[i];
                end
            m_out = out0 & ~drv_res_v;
            if (g >= 0) begin
                m_out[g] = 1'b1;
                lane_row[g] = exp_row();
                lane_col[g] = exp_col();
                lane_t[g] = $urandom_range(lat_hi, lat_lo);
                m_issued++;
            end
            if (m_busy && iss0 == m_total && out0 == '0) begin
                m_busy = 0;
                m_done = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_search(input int mr, input int mc, input logic [NL-1:0] rdy_mask,
                              input bit rand_rdy, input int lo, input int hi, input int budget);
        int cyc;
        drv_mr = mr; drv_mc = mc; lat_lo = lo; lat_hi = hi;
        drv_ready = rdy_mask; drv_res_v = '0; drv_start = 1'b1;
        tick();
        cyc = 0;
        while (!m_done && cyc < budget) begin
            drv_ready = rand_rdy ? (NL'($urandom) & rdy_mask) : rdy_mask;
            drv_res_v = '0;
            for (int i = 0; i < NL; i++) begin
                if (m_out[i]) begin
                    if (lane_t[i] == 0) begin
                        drv_res_v[i] = 1'b1;
                        drv_sad[i] = SW'($urandom_range(30, 0));
                    end else begin
                        lane_t[i]--;
                    end
                end else if ($urandom_range(7, 0) == 0) begin
                    drv_res_v[i] = 1'b1;
                    drv_sad[i] = '0;
                end
            end
            // Start pulses while busy must be ignored.
            drv_start = ($urandom_range(15, 0) == 0);
            tick();
            cyc++;
        end
        drv_start = 1'b0;
        drv_res_v = '0;
        chk("done_at_end", 32'(done), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; max_row = '0; max_col = '0;
        job_ready = '0; res_valid = '0; res_sad = '0; res_row = '0; res_col = '0;
        drv_ready = '0; drv_res_v = '0; drv_start = 1'b0;
        drv_mr = 0; drv_mc = 0; lat_lo = 0; lat_hi = 0;
        for (int i = 0; i < NL; i++) begin
            drv_sad[i] = '0; lane_row[i] = 0; lane_col[i] = 0; lane_t[i] = 0;
        end
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Fill all eight lanes with one row of eight windows, then return results by hand.
        drv_mr = 0; drv_mc = 7; drv_ready = '1; drv_start = 1'b1;
        tick();
        drv_start = 1'b0;
        repeat (8) tick();
        drv_ready = '0;
        drv_res_v = 8'h01; drv_sad[0] = 100; tick();
        drv_res_v = 8'h28; drv_sad[3] = 40; drv_sad[5] = 40; tick();
        chk("min_tie_lane3_sad", min_sad, 32'd40);
        chk("min_tie_lane3_col", 32'(min_col), 32'd3);
        drv_res_v = 8'h10; drv_sad[4] = 40; tick();
        chk("min_equal_kept_col", 32'(min_col), 32'd3);
        drv_res_v = 8'h08; drv_sad[3] = 0; tick();
        chk("stale_result_ignored", min_sad, 32'd40);
        drv_res_v = 8'h40; drv_sad[6] = 39; tick();
        drv_res_v = '0; tick();
        chk("min_39_sad", min_sad, 32'd39);
        chk("min_39_col", 32'(min_col), 32'd6);

        // Reset between edges while lanes 1, 2 and 7 still hold jobs.
        #2 rst = 1'b1;
        #1;
        chk("rst_job_valid", 32'(job_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_min_sad", min_sad, 32'hFFFF_FFFF);
        chk("rst_min_col", 32'(min_col), 32'd0);
        chk("rst_job_col", 32'(job_col), 32'd0);
        m_reset();
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        // Abandoned lane reports afterwards: must be ignored.
        drv_res_v = 8'h86; drv_sad[1] = 0; drv_sad[2] = 0; drv_sad[7] = 0; tick();
        drv_res_v = '0; tick();

        run_search(1, 2, 8'hFF, 1'b0, 8, 12, 200);
        run_search(2, 3, 8'h04, 1'b0, 0, 3, 500);
        run_search(0, 0, 8'hFF, 1'b1, 0, 3, 100);
        for (int k = 0; k < 6; k++)
            run_search($urandom_range(4, 0), $urandom_range(5, 0), '1, 1'b1, 0, 6, 2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
